// File: rtl/alu_pkg.sv
// Shared encodings for seq_alu: RISC-V funct3/funct7 decode values, FSM states
// and the operation selector handed to the iterative multiply/divide unit.
package alu_pkg;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SLT   = 3'b010;
    localparam logic [2:0] F3_SLTU  = 3'b011;
    localparam logic [2:0] F3_XOR   = 3'b100;
    localparam logic [2:0] F3_SRL   = 3'b101;
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_AND   = 3'b111;

    localparam logic [2:0] F3_MUL   = 3'b000;
    localparam logic [2:0] F3_MULHU = 3'b011;
    localparam logic [2:0] F3_DIVU  = 3'b101;
    localparam logic [2:0] F3_REMU  = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    typedef enum logic [1:0] {MDU_MUL, MDU_MULHU, MDU_DIVU, MDU_REMU} mdu_op_t;

    typedef enum logic [1:0] {CLS_SINGLE, CLS_MDU, CLS_ILLEGAL} op_class_t;

    function automatic op_class_t classify(input logic [2:0] f3, input logic [6:0] f7);
        op_class_t cls;
        cls = CLS_ILLEGAL;
        if (f7 == F7_BASE) begin
            cls = CLS_SINGLE;
        end else if (f7 == F7_ALT) begin
            if (f3 == F3_ADD || f3 == F3_SRL) cls = CLS_SINGLE;
        end else if (f7 == F7_MDU) begin
            if (f3 == F3_MUL || f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU)
                cls = CLS_MDU;
        end
        return cls;
    endfunction

    function automatic mdu_op_t to_mdu_op(input logic [2:0] f3);
        mdu_op_t op;
        case (f3)
            F3_MUL:   op = MDU_MUL;
            F3_MULHU: op = MDU_MULHU;
            F3_DIVU:  op = MDU_DIVU;
            default:  op = MDU_REMU;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/seq_alu_mdu.sv
// Iterative multiply/divide unit: XLEN-step shift-add multiply and restoring
// divide sharing one accumulator/shift register pair.
module seq_alu_mdu
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic            busy;
    logic [CW-1:0]   cnt;
    mdu_op_t         op_q;
    logic [XLEN-1:0] opnd;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] qr;

    logic            is_div;
    logic            start_div;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   r_sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] acc_nx;
    logic [XLEN-1:0] qr_nx;

    // acc holds the product high half / partial remainder; qr holds the
    // multiplier being shifted out / dividend being shifted into quotient.
    always_comb begin
        is_div    = (op_q == MDU_DIVU) || (op_q == MDU_REMU);
        start_div = (mdu_op_t'(op) == MDU_DIVU) || (mdu_op_t'(op) == MDU_REMU);
        sum       = {1'b0, acc} + (qr[0] ? {1'b0, opnd} : '0);
        r_sh      = {acc, qr[XLEN-1]};
        diff      = r_sh - {1'b0, opnd};
        if (is_div) begin
            if (!diff[XLEN]) begin
                acc_nx = diff[XLEN-1:0];
                qr_nx  = {qr[XLEN-2:0], 1'b1};
            end else begin
                acc_nx = r_sh[XLEN-1:0];
                qr_nx  = {qr[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nx = sum[XLEN:1];
            qr_nx  = {sum[0], qr[XLEN-1:1]};
        end
        done = busy && (cnt == CW'(XLEN - 1));
        case (op_q)
            MDU_MUL:   result = qr_nx;
            MDU_MULHU: result = acc_nx;
            MDU_DIVU:  result = qr_nx;
            default:   result = acc_nx;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            op_q <= MDU_MUL;
            opnd <= '0;
            acc  <= '0;
            qr   <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            op_q <= mdu_op_t'(op);
            opnd <= start_div ? b : a;
            acc  <= '0;
            qr   <= start_div ? a : b;
        end else if (busy) begin
            acc <= acc_nx;
            qr  <= qr_nx;
            cnt <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential RV64 ALU with M-extension subset: single-cycle base ops, iterative
// multiply/divide, valid/ready handshakes on both sides, one op in flight.
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            err
);

    state_t          state;
    op_class_t       cls;
    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            mdu_start;
    logic [1:0]      mdu_op;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;

    assign accept    = in_valid && in_ready;
    assign mdu_start = accept && (cls == CLS_MDU);
    assign mdu_op    = to_mdu_op(funct3);

    always_comb begin
        cls     = classify(funct3, funct7);
        shamt   = rs2[SHW-1:0];
        alu_res = '0;
        case (funct3)
            F3_ADD: begin
                if (funct7 == F7_ALT) alu_res = rs1 - rs2;
                else                  alu_res = rs1 + rs2;
            end
            F3_SLL:  alu_res = rs1 << shamt;
            F3_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(rs2)};
            F3_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1 < rs2};
            F3_XOR:  alu_res = rs1 ^ rs2;
            F3_SRL: begin
                // kept as separate assignments so the signed shift is not
                // coerced to unsigned by a shared expression context
                if (funct7 == F7_ALT) alu_res = $signed(rs1) >>> shamt;
                else                  alu_res = rs1 >> shamt;
            end
            F3_OR:   alu_res = rs1 | rs2;
            default: alu_res = rs1 & rs2;
        endcase
    end

    seq_alu_mdu #(
        .XLEN (XLEN)
    ) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mdu_start),
        .op     (mdu_op),
        .a      (rs1),
        .b      (rs2),
        .done   (mdu_done),
        .result (mdu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rd        <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        case (cls)
                            CLS_SINGLE: begin
                                state     <= DONE;
                                out_valid <= 1'b1;
                                rd        <= alu_res;
                                err       <= 1'b0;
                            end
                            CLS_MDU: begin
                                state <= CALC;
                            end
                            default: begin
                                state     <= DONE;
                                out_valid <= 1'b1;
                                rd        <= '0;
                                err       <= 1'b1;
                            end
                        endcase
                    end
                end
                CALC: begin
                    if (mdu_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        rd        <= mdu_result;
                        err       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (XLEN=64): directed vectors, randomized ops
// against an arithmetic reference model, backpressure and mid-operation reset.
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] rd;
    logic        err;

    int checks = 0;
    int passed = 0;

    seq_alu #(
        .XLEN (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .funct7    (funct7),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, checks);
        $fatal(1, "watchdog");
    end

    // Reference: results straight from the arithmetic definitions.
    function automatic void ref_model(input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] r, output logic e, output int lat);
        logic [127:0] p;
        logic [63:0]  ones;
        int sh;
        ones = 64'hFFFF_FFFF_FFFF_FFFF;
        sh   = int'(b[5:0]);
        r    = 64'd0;
        e    = 1'b0;
        lat  = 1;
        if (f7 == 7'h00) begin
            case (f3)
                3'd0: r = a + b;
                3'd1: r = a << sh;
                3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                3'd3: r = (a < b) ? 64'd1 : 64'd0;
                3'd4: r = a ^ b;
                3'd5: r = a >> sh;
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
            r = a - b;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
            r = (a >> sh) | (a[63] ? ~(ones >> sh) : 64'd0);
        end else if (f7 == 7'h01 && (f3 == 3'd0 || f3 == 3'd3 || f3 == 3'd5 || f3 == 3'd7)) begin
            lat = 65;
            p = {64'd0, a} * {64'd0, b};
            case (f3)
                3'd0:    r = p[63:0];
                3'd3:    r = p[127:64];
                3'd5:    r = (b == 64'd0) ? ones : a / b;
                default: r = (b == 64'd0) ? a : a % b;
            endcase
        end else begin
            e = 1'b1;
        end
    endfunction

    // Issues one request from a negedge, scrambles inputs after accept,
    // measures cycles to out_valid and completes the output handshake.
    task automatic run_op(input logic [2:0] f3, input logic [6:0] f7,
                          input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] r, output logic e, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        funct3   = f3;
        funct7   = f7;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        funct7   = 7'($urandom);
        rs1      = {$urandom, $urandom};
        rs2      = {$urandom, $urandom};
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r = rd;
        e = err;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        funct3    = 3'd0;
        funct7    = 7'd0;
        rs1       = 64'd0;
        rs2       = 64'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else passed++;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else passed++;
        checks++;
        if (rd !== 64'd0) $display("FAIL reset_rd: got %h want 0", rd);
        else passed++;
        checks++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [2:0]  f3  [10];
        logic [6:0]  f7  [10];
        logic [63:0] a   [10];
        logic [63:0] b   [10];
        logic [63:0] exp [10];
        int          el  [10];
        logic [63:0] r;
        logic        e;
        int          lat;
        f3[0] = 3'd0; f7[0] = 7'h00; a[0] = 64'd5; b[0] = 64'd7; exp[0] = 64'd12; el[0] = 1;
        f3[1] = 3'd0; f7[1] = 7'h20; a[1] = 64'd5; b[1] = 64'd7; exp[1] = 64'hFFFF_FFFF_FFFF_FFFE; el[1] = 1;
        f3[2] = 3'd5; f7[2] = 7'h20; a[2] = 64'h8000_0000_0000_0000; b[2] = 64'd63; exp[2] = 64'hFFFF_FFFF_FFFF_FFFF; el[2] = 1;
        f3[3] = 3'd5; f7[3] = 7'h00; a[3] = 64'h8000_0000_0000_0000; b[3] = 64'd63; exp[3] = 64'd1; el[3] = 1;
        f3[4] = 3'd3; f7[4] = 7'h01; a[4] = 64'hFFFF_FFFF_FFFF_FFFF; b[4] = 64'd2; exp[4] = 64'd1; el[4] = 65;
        f3[5] = 3'd0; f7[5] = 7'h01; a[5] = 64'hFFFF_FFFF_FFFF_FFFF; b[5] = 64'd2; exp[5] = 64'hFFFF_FFFF_FFFF_FFFE; el[5] = 65;
        f3[6] = 3'd5; f7[6] = 7'h01; a[6] = 64'd100; b[6] = 64'd0; exp[6] = 64'hFFFF_FFFF_FFFF_FFFF; el[6] = 65;
        f3[7] = 3'd7; f7[7] = 7'h01; a[7] = 64'd100; b[7] = 64'd0; exp[7] = 64'd100; el[7] = 65;
        f3[8] = 3'd5; f7[8] = 7'h01; a[8] = 64'd100; b[8] = 64'd7; exp[8] = 64'd14; el[8] = 65;
        f3[9] = 3'd7; f7[9] = 7'h01; a[9] = 64'd100; b[9] = 64'd7; exp[9] = 64'd2; el[9] = 65;
        for (int i = 0; i < 10; i++) begin
            run_op(f3[i], f7[i], a[i], b[i], r, e, lat);
            checks++;
            if (r !== exp[i]) $display("FAIL directed_rd[%0d]: got %h want %h", i, r, exp[i]);
            else passed++;
            checks++;
            if (e !== 1'b0) $display("FAIL directed_err[%0d]: got %b want 0", i, e);
            else passed++;
            checks++;
            if (lat != el[i]) $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, el[i]);
            else passed++;
        end
    endtask

    task automatic test_random_single;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] a, b, r, er;
        logic        e, ee;
        int          lat, el, sel;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8) begin
                f7 = 7'h00;
                f3 = 3'(sel);
            end else begin
                f7 = 7'h20;
                f3 = (sel == 8) ? 3'd0 : 3'd5;
            end
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) b = a;
            run_op(f3, f7, a, b, r, e, lat);
            ref_model(f3, f7, a, b, er, ee, el);
            checks++;
            if (r !== er || e !== ee || lat != el)
                $display("FAIL random_single[%0d] f7=%h f3=%0d a=%h b=%h: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                         i, f7, f3, a, b, r, e, lat, er, ee, el);
            else passed++;
        end
    endtask

    task automatic test_random_mdu;
        logic [2:0]  f3;
        logic [63:0] a, b, r, er;
        logic        e, ee;
        int          lat, el, sel;
        for (int i = 0; i < 12; i++) begin
            sel = int'($urandom_range(0, 3));
            f3 = (sel == 0) ? 3'd0 : (sel == 1) ? 3'd3 : (sel == 2) ? 3'd5 : 3'd7;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) b = 64'($urandom_range(0, 1000));
            if ($urandom_range(0, 5) == 0) b = 64'd0;
            run_op(f3, 7'h01, a, b, r, e, lat);
            ref_model(f3, 7'h01, a, b, er, ee, el);
            checks++;
            if (r !== er || e !== ee || lat != el)
                $display("FAIL random_mdu[%0d] f3=%0d a=%h b=%h: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                         i, f3, a, b, r, e, lat, er, ee, el);
            else passed++;
        end
    endtask

    task automatic test_illegal;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] a, b, r, er;
        logic        e, ee;
        int          lat, el, sel;
        logic [2:0]  alt_bad [6];
        logic [2:0]  mdu_bad [4];
        alt_bad[0] = 3'd1; alt_bad[1] = 3'd2; alt_bad[2] = 3'd3;
        alt_bad[3] = 3'd4; alt_bad[4] = 3'd6; alt_bad[5] = 3'd7;
        mdu_bad[0] = 3'd1; mdu_bad[1] = 3'd2; mdu_bad[2] = 3'd4; mdu_bad[3] = 3'd6;
        for (int i = 0; i < 10; i++) begin
            sel = int'($urandom_range(0, 2));
            f3  = 3'($urandom);
            if (sel == 0) begin
                f7 = 7'($urandom_range(2, 127));
                if (f7 == 7'h20) f7 = 7'h40;
            end else if (sel == 1) begin
                f7 = 7'h20;
                f3 = alt_bad[$urandom_range(0, 5)];
            end else begin
                f7 = 7'h01;
                f3 = mdu_bad[$urandom_range(0, 3)];
            end
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            run_op(f3, f7, a, b, r, e, lat);
            ref_model(f3, f7, a, b, er, ee, el);
            checks++;
            if (r !== er || e !== ee || lat != el)
                $display("FAIL illegal[%0d] f7=%h f3=%0d: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                         i, f7, f3, r, e, lat, er, ee, el);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] a, b, x, y, held;
        int w;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        held = a ^ b;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        funct3 = 3'd4; funct7 = 7'h00; rs1 = a; rs2 = b; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Next request waits on the bus while the result is held.
        funct3 = 3'd0; funct7 = 7'h00; rs1 = x; rs2 = y;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || rd !== held || in_ready !== 1'b0)
                $display("FAIL backpressure_hold[%0d]: got out_valid=%b rd=%h in_ready=%b want 1 %h 0",
                         c, out_valid, rd, in_ready, held);
            else passed++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL no_bypass: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || rd !== x + y || err !== 1'b0)
            $display("FAIL second_op: got out_valid=%b rd=%h err=%b want 1 %h 0", out_valid, rd, err, x + y);
        else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop;
        logic [63:0] r;
        logic        e;
        int          lat, bad;
        funct3 = 3'd5; funct7 = 7'h01; rs1 = 64'd100; rs2 = 64'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || rd !== 64'd0 || err !== 1'b0)
            $display("FAIL midop_reset_state: got in_ready=%b out_valid=%b rd=%h err=%b want 1 0 0 0",
                     in_ready, out_valid, rd, err);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL midop_discard: got %0d bad cycles want 0", bad);
        else passed++;
        run_op(3'd0, 7'h00, 64'd1, 64'd1, r, e, lat);
        checks++;
        if (r !== 64'd2 || e !== 1'b0 || lat != 1)
            $display("FAIL post_reset_add: got rd=%h err=%b lat=%0d want 2 0 1", r, e, lat);
        else passed++;
        run_op(3'd0, 7'h7F, 64'd9, 64'd3, r, e, lat);
        checks++;
        if (r !== 64'd0 || e !== 1'b1 || lat != 1)
            $display("FAIL post_reset_illegal: got rd=%h err=%b lat=%0d want 0 1 1", r, e, lat);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random_single;
        test_random_mdu;
        test_illegal;
        test_back_to_back;
        test_reset_midop;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width (32 or 64).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid&in_ready.
REQ-008 SHALL have port funct3  input  3  RISC-V funct3.
REQ-009 SHALL have port funct7  input  7  RISC-V funct7.
REQ-010 SHALL have port rs1  input  XLEN  operand A.
REQ-011 SHALL have port rs2  input  XLEN  operand B.
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result when out_valid&out_ready.
REQ-014 SHALL have port rd  output  XLEN  result.
REQ-015 SHALL have port err  output  1  illegal funct3/funct7 encoding, qualified by out_valid.

Function
REQ-016 SHALL capture funct3, funct7, rs1, rs2 on the accept edge; later input changes have no effect.
REQ-017 SHALL implement funct7=0000000: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND; funct7=0100000: SUB (f3=000), SRA (f3=101).
REQ-018 SHALL take shift amounts from rs2[SHW-1:0]; the full range 0..XLEN-1 is required.
REQ-019 SHALL implement funct7=0000001: MUL (000, low XLEN), MULHU (011, high XLEN unsigned), DIVU (101), REMU (111).
REQ-020 SHALL wrap ADD, SUB and MUL modulo 2^XLEN; SLT signed, SLTU unsigned, result in bit 0 with all other bits zero.
REQ-021 SHALL return all ones for DIVU by zero and rs1 for REMU by zero, with no error flag.
REQ-022 SHALL, for any other encoding, return rd=0 with err=1 at single-cycle latency.
REQ-023 SHALL use FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE.
REQ-024 SHALL transition IDLE->DONE on accepting a single-cycle op, so out_valid asserts on the next edge.
REQ-025 SHALL transition IDLE->CALC on accepting an M op and stay in CALC exactly XLEN cycles: shift-add for multiply, restoring divide.
REQ-026 SHALL transition CALC->DONE after the last iteration, giving XLEN+1 cycles from accept to out_valid.
REQ-027 SHALL transition DONE->IDLE on out_valid&out_ready; it SHALL hold rd, err and out_valid stable while out_ready=0.
REQ-028 SHALL give no same-cycle bypass from DONE to a new accept; at most one operation is in flight.

Reset
REQ-029 SHALL, while rst_n=0, force state=IDLE, in_ready=1, out_valid=0, rd=0, err=0 and clear the iteration counter.
REQ-030 SHALL discard any CALC or DONE operation when reset asserts mid-operation; that operation produces no output.

Structure
REQ-031 SHALL place the funct3/funct7 encodings and the state enum in shared package alu_pkg.
REQ-032 SHALL isolate the iterative multiply/divide datapath (counter, accumulator, quotient/remainder registers) in sub-module seq_alu_mdu, with a start/done interface to the FSM.

Verification (XLEN=64)
REQ-033 SHALL cover ADD rs1=5, rs2=7 -> rd=12, out_valid one cycle after accept; SUB 5-7 -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-034 SHALL cover SRA rs1=0x8000_0000_0000_0000, rs2=63 -> all ones; SRL same operands -> 1.
REQ-035 SHALL cover MULHU rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 -> rd=1, out_valid 65 cycles after accept; MUL same operands -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-036 SHALL cover DIVU 100/0 -> all ones; REMU 100/0 -> 100; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-037 SHALL cover holding out_ready=0 for 3 cycles in DONE -> rd stable and in_ready=0; a new in_valid is not accepted until after the output handshake.
REQ-038 SHALL cover asserting rst_n=0 at CALC cycle 10 of a DIVU -> out_valid=0 and in_ready=1 after release; the next ADD 1+1 -> 2; funct7=1111111 -> err=1, rd=0.
